// File: rtl/adc_pkg.sv
// Shared sizing helpers and the saturating round used by the ADC capture path.
package adc_pkg;
  localparam int ADC_WIDTH_DEF    = 9;
  localparam int OUT_WIDTH_DEF    = 8;
  localparam int DEPTH_DEF        = 16;
  localparam int MAX_AVG_LOG2_DEF = 3;
  localparam int LEVEL_W          = $clog2(DEPTH_DEF + 1);
  localparam int AVG_LOG2_W       = $clog2(MAX_AVG_LOG2_DEF + 1);

  function automatic int acc_width(input int adc_w, input int max_avg_log2);
    return adc_w + max_avg_log2;
  endfunction

  // Round-half-up by s bits, then clamp to the largest out_w-bit value.
  function automatic logic [31:0] round_sat(input logic [31:0] avg, input int s, input int out_w);
    logic [32:0] sum;
    logic [32:0] lim;
    if (s == 0) return avg;
    sum = {1'b0, avg} + (33'd1 << (s - 1));
    sum = sum >> s;
    lim = (33'd1 << out_w) - 33'd1;
    return (sum > lim) ? lim[31:0] : sum[31:0];
  endfunction
endpackage

// File: rtl/adc_sample_fifo.sv
// Synchronous FIFO with wrap-bit pointers; head holds the last popped word while empty.
module adc_sample_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign level   = $bits(level)'(wr_q - rd_q);
  assign head    = empty ? hold_q : mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d   = wr_q + PW'(do_push);
    rd_d   = rd_q + PW'(do_pop);
    hold_d = do_pop ? mem_q[rd_q[AW-1:0]] : hold_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_q   <= '0;
      rd_q   <= '0;
      hold_q <= '0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      hold_q <= hold_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= push_data;
  end
endmodule

// File: rtl/adc_capture_fifo.sv
// SAR ADC back end: 2^k block averaging, width reduction, result stage and output FIFO.
module adc_capture_fifo
  import adc_pkg::*;
#(
  parameter int ADC_WIDTH    = ADC_WIDTH_DEF,
  parameter int OUT_WIDTH    = OUT_WIDTH_DEF,
  parameter int DEPTH        = DEPTH_DEF,
  parameter int MAX_AVG_LOG2 = MAX_AVG_LOG2_DEF
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              enable,
  input  logic [$clog2(MAX_AVG_LOG2+1)-1:0] avg_log2,
  input  logic                              round_en,
  input  logic                              adc_valid,
  input  logic [ADC_WIDTH-1:0]              adc_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [OUT_WIDTH-1:0]              out_data,
  output logic [$clog2(DEPTH+1)-1:0]        level,
  output logic                              overflow,
  input  logic                              clear_ovf
);
  localparam int ACC_W = acc_width(ADC_WIDTH, MAX_AVG_LOG2);
  localparam int K_W   = $clog2(MAX_AVG_LOG2 + 1);
  localparam int CNT_W = MAX_AVG_LOG2 + 1;
  localparam int S     = ADC_WIDTH - OUT_WIDTH;

  logic [ACC_W-1:0]     acc_q, acc_d, sum, avg_full;
  logic [CNT_W-1:0]     cnt_q, cnt_d, blk_len;
  logic [K_W-1:0]       k_q, k_d, k_eff;
  logic [OUT_WIDTH-1:0] res_q, res_d, red;
  logic                 res_valid_q, res_valid_d;
  logic                 ovf_q, ovf_d;
  logic [ADC_WIDTH-1:0] avg;
  logic                 last, full, empty, pop, drop;

  always_comb begin
    // k is only sampled at the first sample of a block.
    k_eff = k_q;
    if (cnt_q == '0)
      k_eff = (avg_log2 > K_W'(MAX_AVG_LOG2)) ? K_W'(MAX_AVG_LOG2) : avg_log2;
    sum      = acc_q + ACC_W'(adc_data);
    avg_full = sum >> k_eff;
    avg      = avg_full[ADC_WIDTH-1:0];
    blk_len  = CNT_W'(1) << k_eff;
    last     = (cnt_q + CNT_W'(1)) == blk_len;
    red      = round_en ? OUT_WIDTH'(round_sat(32'(avg), S, OUT_WIDTH)) : avg[ADC_WIDTH-1:S];

    acc_d       = acc_q;
    cnt_d       = cnt_q;
    k_d         = k_q;
    res_d       = res_q;
    res_valid_d = 1'b0;
    if (!enable) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (adc_valid) begin
      k_d = k_eff;
      if (last) begin
        acc_d       = '0;
        cnt_d       = '0;
        res_d       = red;
        res_valid_d = 1'b1;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign pop  = out_valid && out_ready;
  assign drop = res_valid_q && full && !pop;

  always_comb begin
    ovf_d = ovf_q;
    if (drop)           ovf_d = 1'b1;
    else if (clear_ovf) ovf_d = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      k_q         <= '0;
      res_q       <= '0;
      res_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      k_q         <= k_d;
      res_q       <= res_d;
      res_valid_q <= res_valid_d;
      ovf_q       <= ovf_d;
    end
  end

  adc_sample_fifo #(.WIDTH(OUT_WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (res_valid_q),
    .push_data (res_q),
    .pop       (pop),
    .head      (out_data),
    .full      (full),
    .empty     (empty),
    .level     (level)
  );

  assign out_valid = !empty;
  assign overflow  = ovf_q;
endmodule

// File: tb/tb_adc_capture_fifo.sv
// Scoreboard bench for adc_capture_fifo: stimulus queues expected words, a negedge monitor checks pops.
module tb_adc_capture_fifo;
  logic       clock = 1'b0;
  logic       reset, enable, round_en, adc_valid, out_ready, clear_ovf;
  logic [1:0] avg_log2;
  logic [8:0] adc_data;
  logic       out_valid, overflow;
  logic [7:0] out_data;
  logic [4:0] level;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];

  adc_capture_fifo #(.ADC_WIDTH(9), .OUT_WIDTH(8), .DEPTH(16), .MAX_AVG_LOG2(3)) dut (
    .clock(clock), .reset(reset), .enable(enable), .avg_log2(avg_log2),
    .round_en(round_en), .adc_valid(adc_valid), .adc_data(adc_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .level(level), .overflow(overflow), .clear_ovf(clear_ovf)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: a word is consumed at the next posedge whenever valid&ready here.
  always @(negedge clock) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_word: got %0d expected none", out_data);
      end else begin
        chk("out_data", out_data, exp_q.pop_front());
      end
    end
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic strobe(input logic [8:0] d);
    adc_data  = d;
    adc_valid = 1'b1;
    tick();
    adc_valid = 1'b0;
  endtask

  task automatic drain(input int max_cyc);
    out_ready = 1'b1;
    for (int i = 0; i < max_cyc && exp_q.size() != 0; i++) tick();
    for (int i = 0; i < 4; i++) tick();
    chk("drain_queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; enable = 1'b1; round_en = 1'b0; avg_log2 = 2'd0;
    adc_valid = 1'b0; adc_data = '0; out_ready = 1'b1; clear_ovf = 1'b0;
    tick(); tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_level", level, 0);
    chk("rst_overflow", overflow, 0);
    reset = 1'b0;
    tick();

    // k=0, truncate, latency
    exp_q.push_back(8'hFF); exp_q.push_back(8'h01); exp_q.push_back(8'h80);
    strobe(9'h1FF);
    chk("lat_n1_out_valid", out_valid, 0);
    strobe(9'h003);
    chk("lat_n2_out_valid", out_valid, 1);
    chk("t1_level_le2", level <= 2, 1);
    strobe(9'h100);
    chk("t1_level_le2b", level <= 2, 1);
    tick();
    chk("t1_level_le2c", level <= 2, 1);
    drain(20);

    // k=2, round with saturation
    avg_log2 = 2'd2; round_en = 1'b1;
    strobe(9'd10); strobe(9'd11); strobe(9'd11); strobe(9'd11);
    exp_q.push_back(8'd5);
    for (int i = 0; i < 4; i++) strobe(9'd511);
    exp_q.push_back(8'd255);
    drain(20);

    // k=3 with mid-block avg_log2 change
    round_en = 1'b0; avg_log2 = 2'd3;
    strobe(9'd80); strobe(9'd88); strobe(9'd96);
    avg_log2 = 2'd0;
    strobe(9'd104); strobe(9'd112); strobe(9'd120); strobe(9'd128); strobe(9'd136);
    exp_q.push_back(8'd54);
    strobe(9'd165);
    exp_q.push_back(8'd82);
    drain(20);

    // Overflow: 20 results into 16 entries
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      strobe(9'(i * 8 + 1));
      exp_q.push_back(8'(i * 4));
    end
    tick(); tick();
    chk("ovf_level16", level, 16);
    chk("ovf_not_yet", overflow, 0);
    for (int i = 16; i < 20; i++) strobe(9'(i * 8 + 1));
    tick(); tick();
    chk("ovf_level16b", level, 16);
    chk("ovf_set", overflow, 1);
    drain(40);
    chk("ovf_drained_level", level, 0);
    chk("ovf_sticky", overflow, 1);
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    chk("ovf_cleared", overflow, 0);

    // Full FIFO with simultaneous push and pop
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      strobe(9'(i * 8 + 3));
      exp_q.push_back(8'(i * 4 + 1));
    end
    tick(); tick();
    chk("full_level16", level, 16);
    strobe(9'h1F0);
    exp_q.push_back(8'hF8);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("pushpop_level16", level, 16);
    chk("pushpop_no_ovf", overflow, 0);
    drain(40);

    // Reset mid-block with queued words
    out_ready = 1'b0; avg_log2 = 2'd0;
    for (int i = 0; i < 5; i++) strobe(9'(i * 2 + 40));
    tick(); tick();
    chk("pre_rst_level5", level, 5);
    avg_log2 = 2'd2;
    strobe(9'd50); strobe(9'd60);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_level", level, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    strobe(9'd100); strobe(9'd104); strobe(9'd108); strobe(9'd112);
    exp_q.push_back(8'd53);
    tick(); tick();
    chk("post_rst_level1", level, 1);
    drain(20);
    chk("post_rst_final_level", level, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/adc_capture_fifo.md
Name: adc_capture_fifo

Overview:
- Parametrised digital back end for the SAR ADC slice.
- Replaces the fixed path that drops the LSB of the 9-bit conversion word and drives 8 pins directly.
- Accepts one conversion word per slice done-strobe, optionally averages 2^k consecutive samples, and reduces the result to the pin width by truncation or rounding with saturation.
- Buffers results in a FIFO drained over a valid/ready interface to the pin serializer, with level and sticky-overflow status.

Parameters:
- ADC_WIDTH, 9: width of the raw conversion word from the slice.
- OUT_WIDTH, 8: width of the output sample; must be <= ADC_WIDTH.
- DEPTH, 16: FIFO entries; power of two, >= 2.
- MAX_AVG_LOG2, 3: largest supported averaging exponent.

Ports:
- clock, input, 1: single clock, same domain as the slice clock.
- reset, input, 1: synchronous, active-high.
- enable, input, 1: capture enable.
- avg_log2, input, $clog2(MAX_AVG_LOG2+1): averaging exponent k; block length is 2^k samples.
- round_en, input, 1: 1 = round-half-up with saturation; 0 = truncate.
- adc_valid, input, 1: one-cycle strobe marking a completed conversion.
- adc_data, input, ADC_WIDTH: conversion word; sampled only when adc_valid = 1.
- out_valid, output, 1: FIFO head is valid.
- out_ready, input, 1: consumer accepts the head.
- out_data, output, OUT_WIDTH: FIFO head.
- level, output, $clog2(DEPTH+1): current FIFO occupancy.
- overflow, output, 1: sticky; a finished result was dropped because the FIFO was full.
- clear_ovf, input, 1: clears overflow.

Behaviour:
- Reset values (synchronous, active-high): out_valid=0, out_data=0, level=0, overflow=0. Accumulator, sample count, and result stage are cleared. Reset mid-block discards the partial block and all FIFO contents.
- Accumulator width is ADC_WIDTH+MAX_AVG_LOG2; it cannot overflow.
- On adc_valid with enable=1:
  - acc <= acc + adc_data; cnt <= cnt + 1.
  - When cnt == 0, k is latched from avg_log2. Changing avg_log2 mid-block has no effect until the next block.
- Block complete when the accepted sample is the (2^k)th:
  - avg = (acc + adc_data) >> k, giving ADC_WIDTH bits.
  - acc and cnt return to 0 in the same cycle, so back-to-back adc_valid strobes lose no samples.
- Width reduction, with S = ADC_WIDTH-OUT_WIDTH:
  - Truncate: avg[ADC_WIDTH-1:S].
  - Round: (avg + 2^(S-1)) >> S, saturated to 2^OUT_WIDTH-1.
  - When S = 0, both modes pass avg through unchanged.
- Pipeline:
  - Completing adc_valid in cycle N → reduced result registered in the stage register (res_valid) at edge N+1.
  - Stage register is written into the FIFO at edge N+2.
  - out_valid rises in cycle N+2 when the FIFO was empty.
  - Throughput: one result per cycle.
- FIFO handshake:
  - Pop occurs on out_valid & out_ready.
  - out_data is stable while out_valid=1 and out_ready=0.
  - level updates on the edge after a push or pop; a simultaneous push and pop leaves level unchanged.
- Full FIFO:
  - A push while level==DEPTH with no pop in the same cycle is dropped and overflow is set.
  - A push coinciding with a pop while full is accepted.
  - Empty FIFO: out_valid=0 and out_data holds its last value.
- overflow: clear_ovf=1 clears it. If a drop and clear_ovf occur in the same cycle, the set wins.
- enable=0:
  - adc_valid is ignored; acc and cnt are cleared.
  - A result already in the stage register still enters the FIFO.
  - The FIFO continues to drain normally.

Decomposition:
- Package adc_pkg:
  - Function acc_width(ADC_WIDTH, MAX_AVG_LOG2).
  - Saturating round function.
  - Localparams for level width and avg_log2 width.
- Sub-module adc_sample_fifo: synchronous FIFO with parameters WIDTH and DEPTH, power-of-two pointers plus a wrap bit, exposing push, pop, full, empty, and level.
- Averaging and reduction logic stays in adc_capture_fifo.

Test Plan:
- k=0, round_en=0, out_ready=1; adc_data 9'h1FF, 9'h003, 9'h100 on consecutive cycles → out_data 8'hFF, 8'h01, 8'h80, first out_valid 2 cycles after the first strobe, level never exceeds 2.
- k=2, round_en=1; samples 10, 11, 11, 11 → avg = 43>>2 = 10 → out 5. Samples 511×4 → avg 511 → round saturates → out 255.
- k=3; avg_log2 changed to 0 after the 3rd sample → the block still completes at the 8th sample, and the next block uses k=0.
- out_ready=0, k=0, 20 strobes with DEPTH=16 → level=16 and overflow=1 after the 17th result. Then out_ready=1 → exactly 16 words in order (first 16 inputs). clear_ovf → overflow=0.
- FIFO full with out_ready=1 in the same cycle a result arrives → push accepted, level stays 16, overflow stays 0.
- Reset asserted after 2 of 4 samples (k=2) and with 5 words queued → next cycle level=0, out_valid=0. A fresh 4-sample block yields exactly one correct word.
